// File: rtl/csr_regfile_if.sv
// Access stream between the AHB subordinate CSR bridge (master) and the register bank (slave).
interface csr_regfile_if;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          sub_valid_i;
  logic          sub_ready_o;
  logic [AW-1:0] sub_addr_i;
  logic          sub_write_i;
  logic [DW-1:0] sub_wdata_i;
  logic [DW-1:0] sub_rdata_o;

  modport master (
    output sub_valid_i, sub_addr_i, sub_write_i, sub_wdata_i,
    input  sub_ready_o, sub_rdata_o
  );

  modport slave (
    input  sub_valid_i, sub_addr_i, sub_write_i, sub_wdata_i,
    output sub_ready_o, sub_rdata_o
  );
endinterface

// File: rtl/csr_regfile.sv
// Control/status/argument/result register bank that launches one compute-core job
// and raises a level interrupt on completion. One wait state per access.
module csr_regfile #(
  parameter logic [31:0] ID_VALUE = 32'h4D52_0001,
  parameter int unsigned NUM_ARGS = 4,
  parameter int unsigned NUM_RES  = 4
) (
  input  logic                    hclk_i,
  input  logic                    hreset_ni,
  csr_regfile_if.slave            sub,
  output logic                    core_start_o,
  output logic [32*NUM_ARGS-1:0]  core_arg_o,
  input  logic                    core_done_i,
  input  logic [32*NUM_RES-1:0]   core_result_i,
  output logic                    irq_o
);

  localparam int unsigned DW       = 32;
  localparam int unsigned IW       = 4;
  localparam int unsigned ARG_BASE = 4;
  localparam int unsigned RES_BASE = 8;

  localparam logic [IW-1:0] IDX_ID     = IW'(0);
  localparam logic [IW-1:0] IDX_CTRL   = IW'(1);
  localparam logic [IW-1:0] IDX_STATUS = IW'(2);
  localparam logic [IW-1:0] IDX_CYCLES = IW'(3);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic                         rd_load_c;
  logic                         wr_commit_c;
  logic [IW-1:0]                idx;
  logic                         unused_addr;

  logic                         ready_q;
  logic [DW-1:0]                rdata_q;
  logic [DW-1:0]                rd_mux_c;

  logic                         busy_q;
  logic                         done_q;
  logic                         done_d;
  logic                         irq_en_q;
  logic                         irq_en_d;
  logic [DW-1:0]                cycles_q;
  logic [NUM_ARGS-1:0][DW-1:0]  args_q;
  logic [NUM_RES-1:0][DW-1:0]   res_q;

  logic                         wr_ctrl_c;
  logic                         wr_status_c;
  logic                         done_hit_c;
  logic                         start_acc_c;
  logic                         done_clr_c;

  // Only the word-select bits of the byte address matter
  assign idx         = sub.sub_addr_i[5:2];
  assign unused_addr = ^{sub.sub_addr_i[31:6], sub.sub_addr_i[1:0]};

  // Access FSM: state register
  always_ff @(posedge hclk_i or negedge hreset_ni) begin
    if (!hreset_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Access FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (sub.sub_valid_i) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Access FSM: outputs (read capture in IDLE, write commit in ACK)
  always_comb begin
    rd_load_c   = 1'b0;
    wr_commit_c = 1'b0;
    unique case (state_q)
      ST_IDLE: rd_load_c   = sub.sub_valid_i & ~sub.sub_write_i;
      ST_ACK:  wr_commit_c = sub.sub_valid_i &  sub.sub_write_i;
      default: ;
    endcase
  end

  // Read mux; unmapped words and unused bits read as zero
  always_comb begin
    rd_mux_c = '0;
    unique case (idx)
      IDX_ID:     rd_mux_c = ID_VALUE;
      IDX_CTRL:   rd_mux_c = {30'b0, irq_en_q, 1'b0};
      IDX_STATUS: rd_mux_c = {30'b0, done_q, busy_q};
      IDX_CYCLES: rd_mux_c = cycles_q;
      default: begin
        for (int unsigned i = 0; i < NUM_ARGS; i++)
          if (idx == IW'(ARG_BASE + i)) rd_mux_c = args_q[i];
        for (int unsigned i = 0; i < NUM_RES; i++)
          if (idx == IW'(RES_BASE + i)) rd_mux_c = res_q[i];
      end
    endcase
  end

  // Bus response flops
  always_ff @(posedge hclk_i or negedge hreset_ni) begin
    if (!hreset_ni) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= (state_d == ST_ACK);
      if (rd_load_c) rdata_q <= rd_mux_c;
    end
  end

  // Job control decode; a done pulse frees the core for a coincident start
  always_comb begin
    wr_ctrl_c   = wr_commit_c & (idx == IDX_CTRL);
    wr_status_c = wr_commit_c & (idx == IDX_STATUS);
    done_hit_c  = core_done_i & busy_q;
    start_acc_c = wr_ctrl_c & sub.sub_wdata_i[0] & (~busy_q | done_hit_c);
    done_clr_c  = wr_status_c & sub.sub_wdata_i[1];

    irq_en_d = irq_en_q;
    if (wr_ctrl_c) irq_en_d = sub.sub_wdata_i[1];

    // Set beats W1C; a new start clears the previous completion
    done_d = done_q;
    if (done_clr_c)  done_d = 1'b0;
    if (done_hit_c)  done_d = 1'b1;
    if (start_acc_c) done_d = 1'b0;
  end

  // Job state
  always_ff @(posedge hclk_i or negedge hreset_ni) begin
    if (!hreset_ni) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_o        <= 1'b0;
      core_start_o <= 1'b0;
      cycles_q     <= '0;
      res_q        <= '0;
    end else begin
      done_q       <= done_d;
      irq_en_q     <= irq_en_d;
      irq_o        <= done_d & irq_en_d;
      core_start_o <= start_acc_c;

      if (start_acc_c)     busy_q <= 1'b1;
      else if (done_hit_c) busy_q <= 1'b0;

      // Counter freezes on the completion cycle and saturates
      if (start_acc_c)
        cycles_q <= '0;
      else if (busy_q && !done_hit_c && (cycles_q != '1))
        cycles_q <= cycles_q + DW'(1);

      if (done_hit_c) res_q <= core_result_i;
    end
  end

  // Argument words, writable at any time
  always_ff @(posedge hclk_i or negedge hreset_ni) begin
    if (!hreset_ni) begin
      args_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ARGS; i++)
        if (wr_commit_c && (idx == IW'(ARG_BASE + i))) args_q[i] <= sub.sub_wdata_i;
    end
  end

  assign core_arg_o      = args_q;
  assign sub.sub_ready_o = ready_q;
  assign sub.sub_rdata_o = rdata_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboard bench for csr_regfile: expected read data is queued when an access is
// driven and compared when the DUT acknowledges it.
module tb_csr_regfile;
  localparam logic [31:0] ID_VAL = 32'h4D52_0001;

  logic         hclk_i = 1'b0;
  logic         hreset_ni = 1'b0;
  logic         core_start_o;
  logic [127:0] core_arg_o;
  logic         core_done_i = 1'b0;
  logic [127:0] core_result_i = '0;
  logic         irq_o;

  csr_regfile_if bus ();

  csr_regfile #(.ID_VALUE(ID_VAL), .NUM_ARGS(4), .NUM_RES(4)) dut (
    .hclk_i        (hclk_i),
    .hreset_ni     (hreset_ni),
    .sub           (bus.slave),
    .core_start_o  (core_start_o),
    .core_arg_o    (core_arg_o),
    .core_done_i   (core_done_i),
    .core_result_i (core_result_i),
    .irq_o         (irq_o)
  );

  always #5 hclk_i = ~hclk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int start_cyc = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always @(posedge hclk_i) cyc <= cyc + 1;

  always @(negedge hclk_i) begin
    if (core_start_o) begin
      starts++;
      start_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_rd, input string tag);
    int lat;
    lat = -1;
    @(posedge hclk_i); #1;
    bus.sub_valid_i = 1'b1;
    bus.sub_write_i = wr;
    bus.sub_addr_i  = addr;
    bus.sub_wdata_i = data;
    if (!wr) begin
      exp_q.push_back(exp_rd);
      tag_q.push_back(tag);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge hclk_i);
      if (bus.sub_ready_o) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    if (!wr && lat >= 0) chk(tag_q.pop_front(), bus.sub_rdata_o, exp_q.pop_front());
    @(posedge hclk_i); #1;
    bus.sub_valid_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    access(1'b0, addr, 32'h0, exp, tag);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string tag);
    access(1'b1, addr, data, 32'h0, tag);
  endtask

  task automatic pulse_done(input logic [127:0] res);
    @(posedge hclk_i); #1;
    core_done_i   = 1'b1;
    core_result_i = res;
    @(posedge hclk_i); #1;
    core_done_i   = 1'b0;
  endtask

  initial begin
    int base;
    int ack_cyc[$];
    bus.sub_valid_i = 1'b0;
    bus.sub_write_i = 1'b0;
    bus.sub_addr_i  = '0;
    bus.sub_wdata_i = '0;

    // Reset
    repeat (3) @(posedge hclk_i);
    @(negedge hclk_i);
    chk("rst_ready", 32'(bus.sub_ready_o), 32'd0);
    chk("rst_irq",   32'(irq_o), 32'd0);
    chk("rst_start", 32'(core_start_o), 32'd0);
    hreset_ni = 1'b1;

    rd(32'h00, ID_VAL, "id");
    rd(32'h30, 32'h0, "unmapped_rd");
    rd(32'h08, 32'h0, "status_rst");
    rd(32'h24, 32'h0, "res1_rst");

    // Arguments, RO drop, unmapped drop
    wr(32'h14, 32'hDEAD_BEEF, "arg1_wr");
    rd(32'h14, 32'hDEAD_BEEF, "arg1_rd");
    @(negedge hclk_i);
    chk("core_arg1", core_arg_o[63:32], 32'hDEAD_BEEF);
    chk("core_arg0", core_arg_o[31:0], 32'h0);
    wr(32'h20, 32'hFFFF_FFFF, "res0_wr");
    rd(32'h20, 32'h0, "res0_ro");
    wr(32'h34, 32'h1234_0000, "unmapped_wr");
    rd(32'h34, 32'h0, "unmapped_rd2");
    wr(32'h00, 32'h0, "id_wr");
    rd(32'h00, ID_VAL, "id_ro");

    // Job with done 10 cycles after the start pulse
    base = starts;
    wr(32'h04, 32'h3, "ctrl_start");
    rd(32'h08, 32'h1, "status_busy");
    for (int i = 0; i < 50; i++) begin
      if (cyc == start_cyc + 10) break;
      @(posedge hclk_i); #1;
    end
    core_done_i   = 1'b1;
    core_result_i = {32'h0, 32'h0, 32'hCAFE_0001, 32'h1234_5678};
    @(posedge hclk_i); #1;
    core_done_i   = 1'b0;
    @(negedge hclk_i);
    chk("job_irq", 32'(irq_o), 32'd1);
    chk("job_pulses", 32'(starts - base), 32'd1);
    rd(32'h08, 32'h2, "status_done");
    rd(32'h0C, 32'd10, "cycles");
    rd(32'h20, 32'h1234_5678, "res0");
    rd(32'h24, 32'hCAFE_0001, "res1");
    rd(32'h04, 32'h2, "ctrl_rd");

    // START while busy is ignored, counter keeps running
    base = starts;
    wr(32'h04, 32'h1, "start2");
    wr(32'h04, 32'h1, "start_busy");
    @(negedge hclk_i);
    chk("busy_pulses", 32'(starts - base), 32'd1);
    rd(32'h0C, 32'(cyc + 1 - start_cyc), "cycles_run");
    pulse_done({64'h0, 32'h1111_2222, 32'hA5A5_0001});
    pulse_done({64'h0, 32'h3333_4444, 32'h0BAD_0BAD});
    rd(32'h20, 32'hA5A5_0001, "res0_idle_done");
    rd(32'h24, 32'h1111_2222, "res1_idle_done");
    rd(32'h08, 32'h2, "status_idle_done");
    @(negedge hclk_i);
    chk("irq_masked", 32'(irq_o), 32'd0);

    // W1C coincident with done: set wins
    wr(32'h04, 32'h3, "start3");
    fork
      wr(32'h08, 32'h2, "w1c_race");
      begin
        @(posedge hclk_i); @(posedge hclk_i); #1;
        core_done_i = 1'b1;
        @(posedge hclk_i); #1;
        core_done_i = 1'b0;
      end
    join
    @(negedge hclk_i);
    chk("race_irq", 32'(irq_o), 32'd1);
    rd(32'h08, 32'h2, "race_status");
    wr(32'h08, 32'h2, "w1c");
    @(negedge hclk_i);
    chk("w1c_irq", 32'(irq_o), 32'd0);
    rd(32'h08, 32'h0, "w1c_status");

    // Back-to-back accesses, then reset mid-access
    wr(32'h04, 32'h3, "start4");
    pulse_done('0);
    wr(32'h10, 32'h55, "arg0_wr");
    @(negedge hclk_i);
    chk("pre_rst_irq", 32'(irq_o), 32'd1);
    @(posedge hclk_i); #1;
    bus.sub_valid_i = 1'b1;
    bus.sub_write_i = 1'b0;
    bus.sub_addr_i  = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge hclk_i);
      if (bus.sub_ready_o) begin
        ack_cyc.push_back(cyc);
        chk("b2b_rdata", bus.sub_rdata_o, ID_VAL);
      end
    end
    chk("b2b_acks", 32'(ack_cyc.size()), 32'd3);
    if (ack_cyc.size() >= 3) begin
      chk("b2b_gap0", 32'(ack_cyc[1] - ack_cyc[0]), 32'd2);
      chk("b2b_gap1", 32'(ack_cyc[2] - ack_cyc[1]), 32'd2);
    end
    @(negedge hclk_i);
    hreset_ni = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.sub_ready_o), 32'd0);
    chk("mid_rst_rdata", bus.sub_rdata_o, 32'h0);
    chk("mid_rst_start", 32'(core_start_o), 32'd0);
    chk("mid_rst_irq",   32'(irq_o), 32'd0);
    chk("mid_rst_arg",   32'(core_arg_o != '0), 32'd0);
    @(posedge hclk_i); #1;
    chk("mid_rst_noack", 32'(bus.sub_ready_o), 32'd0);
    bus.sub_valid_i = 1'b0;
    hreset_ni = 1'b1;
    rd(32'h10, 32'h0, "arg0_after_rst");
    rd(32'h14, 32'h0, "arg1_after_rst");
    rd(32'h04, 32'h0, "ctrl_after_rst");
    rd(32'h0C, 32'h0, "cycles_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
